// File: rtl/time_counter_core.sv
// -----------------------------------------------------------------------------
// time_counter_core
//   Time-of-day counter for the alarm clock. A prescaler divides the board
//   clock down to a one-second advance. Hours, minutes and seconds are kept in
//   24-hour format. The mode input selects run, load-from-inputs or hold.
//
// Ports
//   CLK100MHZ  in   system clock, all logic on the rising edge
//   rst_n      in   synchronous active-low reset
//   state      in   mode: 0 RUN, 1 LOAD, 2 HOLD, 3..7 behave as RUN
//   inseconds  in   seconds to load (out-of-range loads 0)
//   inminutes  in   minutes to load (out-of-range loads 0)
//   inhours    in   hours to load   (out-of-range loads 0)
//   seconds    out  current seconds 0..59, registered
//   minutes    out  current minutes 0..59, registered
//   hours      out  current hours 0..23, registered
//   sec_tick   out  one-cycle pulse aligned with each new seconds value
//
// Mode table
//   mode | meaning
//   RUN  | prescaler counts, time advances on prescaler wrap
//   LOAD | time taken from inputs, prescaler cleared
//   HOLD | time and prescaler frozen
// -----------------------------------------------------------------------------
module time_counter_core #(
    parameter int unsigned TICKS_PER_SEC = 100000000
) (
    input  logic       CLK100MHZ,
    input  logic       rst_n,
    input  logic [2:0] state,
    input  logic [5:0] inseconds,
    input  logic [5:0] inminutes,
    input  logic [4:0] inhours,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic       sec_tick
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        MODE_RUN  = 2'd0,
        MODE_LOAD = 2'd1,
        MODE_HOLD = 2'd2
    } mode_e;

    mode_e         mode;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hr_q, hr_d;
    logic          tick_q, tick_d;

    // Codes 3..7 are folded onto RUN.
    always_comb begin
        case (state)
            3'd1:    mode = MODE_LOAD;
            3'd2:    mode = MODE_HOLD;
            default: mode = MODE_RUN;
        endcase
    end

    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        tick_d  = 1'b0;

        case (mode)
            MODE_LOAD: begin
                // Each field is validated on its own so one bad field does not
                // discard the others.
                sec_d   = (inseconds > 6'd59) ? 6'd0 : inseconds;
                min_d   = (inminutes > 6'd59) ? 6'd0 : inminutes;
                hr_d    = (inhours   > 5'd23) ? 5'd0 : inhours;
                presc_d = '0;
            end
            MODE_HOLD: begin
            end
            default: begin
                if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    if (sec_q == 6'd59) begin
                        sec_d = 6'd0;
                        if (min_q == 6'd59) begin
                            min_d = 6'd0;
                            hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            presc_q <= '0;
            sec_q   <= 6'd0;
            min_q   <= 6'd0;
            hr_q    <= 5'd0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hr_q    <= hr_d;
            tick_q  <= tick_d;
        end
    end

    assign seconds  = sec_q;
    assign minutes  = min_q;
    assign hours    = hr_q;
    assign sec_tick = tick_q;

endmodule

// File: tb/tb_time_counter_core.sv
module tb_time_counter_core;

    localparam int T = 4;

    logic       clk;
    logic       rst_n;
    logic [2:0] state;
    logic [5:0] inseconds;
    logic [5:0] inminutes;
    logic [4:0] inhours;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic       sec_tick;

    int checks = 0;
    int errors = 0;

    // Reference model: time of day as a plain count of seconds since midnight.
    int tod = 0;
    int pc  = 0;
    bit mtick = 0;

    time_counter_core #(.TICKS_PER_SEC(T)) dut (
        .CLK100MHZ (clk),
        .rst_n     (rst_n),
        .state     (state),
        .inseconds (inseconds),
        .inminutes (inminutes),
        .inhours   (inhours),
        .seconds   (seconds),
        .minutes   (minutes),
        .hours     (hours),
        .sec_tick  (sec_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [2:0] m;
        logic [5:0] is;
        logic [5:0] im;
        logic [4:0] ih;
        logic [5:0] es;
        logic [5:0] em;
        logic [4:0] eh;
        logic       et;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [2:0] m,
                       input logic [5:0] is, input logic [5:0] im, input logic [4:0] ih,
                       input logic [4:0] eh, input logic [5:0] em, input logic [5:0] es,
                       input logic et, input int rep);
        vec_t v;
        v.r = r; v.m = m; v.is = is; v.im = im; v.ih = ih;
        v.es = es; v.em = em; v.eh = eh; v.et = et;
        for (int i = 0; i < rep; i++) vq.push_back(v);
    endtask

    // Drive inputs, take one rising edge, update the model, settle to negedge.
    task automatic apply(input logic r, input logic [2:0] m,
                         input logic [5:0] is, input logic [5:0] im, input logic [4:0] ih);
        int ls, lm, lh;
        rst_n = r; state = m; inseconds = is; inminutes = im; inhours = ih;
        @(posedge clk);
        if (!r) begin
            tod = 0; pc = 0; mtick = 0;
        end else if (m == 3'd1) begin
            ls = (is > 59) ? 0 : int'(is);
            lm = (im > 59) ? 0 : int'(im);
            lh = (ih > 23) ? 0 : int'(ih);
            tod = lh * 3600 + lm * 60 + ls;
            pc = 0; mtick = 0;
        end else if (m == 3'd2) begin
            mtick = 0;
        end else begin
            pc = pc + 1;
            mtick = 0;
            if (pc == T) begin
                pc = 0;
                tod = (tod + 1) % 86400;
                mtick = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int eh, input int em, input int es, input bit et);
        checks++;
        if (hours !== 5'(eh) || minutes !== 6'(em) || seconds !== 6'(es) || sec_tick !== et) begin
            errors++;
            $display("FAIL %s: got %0d:%0d:%0d tick=%0b, expected %0d:%0d:%0d tick=%0b",
                     name, hours, minutes, seconds, sec_tick, eh, em, es, et);
        end
    endtask

    initial begin
        int nt;
        int rs, rm, rh;
        logic [2:0] md;
        logic rr;

        rst_n = 1'b0; state = 3'd0; inseconds = '0; inminutes = '0; inhours = '0;

        //   r  mode  is  im  ih    eh  em  es  tick  rep
        add(0, 3'd0,  0,  0,  0,    0,  0,  0,  0,   1);
        add(1, 3'd0,  0,  0,  0,    0,  0,  0,  0,   3);
        add(1, 3'd0,  0,  0,  0,    0,  0,  1,  1,   1);
        add(1, 3'd0,  0,  0,  0,    0,  0,  1,  0,   1);
        add(1, 3'd1, 58, 59, 23,   23, 59, 58,  0,   1);
        add(1, 3'd0,  0,  0,  0,   23, 59, 58,  0,   3);
        add(1, 3'd0,  0,  0,  0,   23, 59, 59,  1,   1);
        add(1, 3'd0,  0,  0,  0,   23, 59, 59,  0,   3);
        add(1, 3'd0,  0,  0,  0,    0,  0,  0,  1,   1);
        add(1, 3'd1, 59, 59, 10,   10, 59, 59,  0,   1);
        add(1, 3'd0,  0,  0,  0,   10, 59, 59,  0,   3);
        add(1, 3'd0,  0,  0,  0,   11,  0,  0,  1,   1);
        add(1, 3'd1, 59, 59,  0,    0, 59, 59,  0,   1);
        add(1, 3'd0,  0,  0,  0,    0, 59, 59,  0,   3);
        add(1, 3'd0,  0,  0,  0,    1,  0,  0,  1,   1);
        add(1, 3'd1, 63, 60, 31,    0,  0,  0,  0,   1);
        add(1, 3'd1, 63, 30, 12,   12, 30,  0,  0,   1);
        add(1, 3'd0,  0,  0,  0,   12, 30,  0,  0,   2);
        add(1, 3'd2, 45, 45, 20,   12, 30,  0,  0,  10);
        add(1, 3'd0,  0,  0,  0,   12, 30,  0,  0,   1);
        add(1, 3'd0,  0,  0,  0,   12, 30,  1,  1,   1);
        add(1, 3'd5,  7,  7,  7,   12, 30,  1,  0,   3);
        add(1, 3'd5,  7,  7,  7,   12, 30,  2,  1,   1);
        add(1, 3'd1, 56, 34, 12,   12, 34, 56,  0,   1);
        add(1, 3'd0,  0,  0,  0,   12, 34, 56,  0,   1);
        add(0, 3'd0,  0,  0,  0,    0,  0,  0,  0,   1);
        add(1, 3'd0,  0,  0,  0,    0,  0,  0,  0,   3);
        add(1, 3'd0,  0,  0,  0,    0,  0,  1,  1,   1);
        add(1, 3'd1, 10, 10, 10,   10, 10, 10,  0,   1);
        add(0, 3'd1, 20, 20, 20,    0,  0,  0,  0,   1);
        add(1, 3'd0,  0,  0,  0,    0,  0,  0,  0,   3);
        add(1, 3'd0,  0,  0,  0,    0,  0,  1,  1,   1);

        foreach (vq[i]) begin
            apply(vq[i].r, vq[i].m, vq[i].is, vq[i].im, vq[i].ih);
            chk($sformatf("vec%0d", i), vq[i].eh, vq[i].em, vq[i].es, vq[i].et);
        end

        // 240 RUN edges from reset: one tick per 4 edges, ending at 00:01:00.
        apply(0, 3'd0, 0, 0, 0);
        chk("rst_240", 0, 0, 0, 0);
        nt = 0;
        for (int i = 1; i <= 240; i++) begin
            apply(1, 3'd0, 0, 0, 0);
            if (sec_tick) nt++;
            if (i == 4) chk("first_adv", 0, 0, 1, 1);
            if (i == 5) chk("tick_one_cycle", 0, 0, 1, 0);
        end
        chk("run_240", 0, 1, 0, 1);
        checks++;
        if (nt != 60) begin
            errors++;
            $display("FAIL tick_count: got %0d, expected 60", nt);
        end

        // Randomized phase against the reference model.
        for (int i = 0; i < 600; i++) begin
            rr = ($urandom_range(0, 49) != 0);
            case ($urandom_range(0, 9))
                0:       md = 3'd1;
                1, 2:    md = 3'd2;
                3:       md = 3'($urandom_range(3, 7));
                default: md = 3'd0;
            endcase
            if ($urandom_range(0, 1) != 0) begin
                rs = $urandom_range(57, 63);
                rm = $urandom_range(58, 63);
                rh = $urandom_range(22, 31);
            end else begin
                rs = $urandom_range(0, 63);
                rm = $urandom_range(0, 63);
                rh = $urandom_range(0, 31);
            end
            apply(rr, md, 6'(rs), 6'(rm), 5'(rh));
            chk($sformatf("rand%0d", i), tod / 3600, (tod / 60) % 60, tod % 60, mtick);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
